// File: rtl/jpeg_sched_pkg.sv
// rtl/jpeg_sched_pkg.sv - shared states, component codes and block geometry for the MCU scheduler
package jpeg_sched_pkg;

    localparam int BLK_SAMPLES  = 64;
    localparam int BLKS_PER_MCU = 6;

    // Last luma block index inside a 4:2:0 MCU (blocks 0..3 are Y)
    localparam logic [2:0] LAST_Y_BLK = 3'd3;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        Y    = 3'd1,
        CB   = 3'd2,
        CR   = 3'd3,
        FIN  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/jpeg_blk_counter.sv
// rtl/jpeg_blk_counter.sv - per-block sample counter and last-sample flag
module jpeg_blk_counter
    import jpeg_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic xfer,
    input  logic valid,
    output logic last
);

    logic [5:0] sample_cnt;

    // Count accepted samples; the 6-bit counter wraps to 0 at the end of every block
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sample_cnt <= '0;
        end else if (xfer) begin
            sample_cnt <= sample_cnt + 6'd1;
        end
    end

    assign last = valid && (sample_cnt == 6'(BLK_SAMPLES - 1));

endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// rtl/jpeg_mcu_scheduler.sv - orders Y/Cb/Cr blocks of 4:2:0 MCUs onto one shared stream
module jpeg_mcu_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MCU_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MCU_W-1:0]  num_mcu,
    input  logic              y_valid,
    input  logic [DATA_W-1:0] y_data,
    output logic              y_ready,
    input  logic              cb_valid,
    input  logic [DATA_W-1:0] cb_data,
    output logic              cb_ready,
    input  logic              cr_valid,
    input  logic [DATA_W-1:0] cr_data,
    output logic              cr_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        out_comp,
    output logic [2:0]        out_blk,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [MCU_W-1:0]  mcu_idx
);

    sched_state_t     state;
    logic [MCU_W-1:0] num_q;
    logic [2:0]       blk;
    logic             xfer;
    logic             blk_end;

    assign out_blk = blk;
    assign xfer    = out_valid && out_ready;
    assign blk_end = xfer && out_last;

    // Route the active component straight through; idle components see ready=0
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_comp  = COMP_Y;
        y_ready   = 1'b0;
        cb_ready  = 1'b0;
        cr_ready  = 1'b0;
        case (state)
            Y: begin
                out_valid = y_valid;
                out_data  = y_data;
                y_ready   = out_ready;
            end
            CB: begin
                out_valid = cb_valid;
                out_data  = cb_data;
                out_comp  = COMP_CB;
                cb_ready  = out_ready;
            end
            CR: begin
                out_valid = cr_valid;
                out_data  = cr_data;
                out_comp  = COMP_CR;
                cr_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Sample counter is held cleared while idle so every frame starts on sample 0
    jpeg_blk_counter u_blk_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == IDLE),
        .xfer  (xfer),
        .valid (out_valid),
        .last  (out_last)
    );

    // Frame FSM: walks blocks 0..5 per MCU, counts MCUs, produces busy and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            num_q   <= '0;
            mcu_idx <= '0;
            blk     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q   <= num_mcu;
                        mcu_idx <= '0;
                        blk     <= '0;
                        if (num_mcu == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= Y;
                            busy  <= 1'b1;
                        end
                    end
                end
                Y: begin
                    if (blk_end) begin
                        blk <= blk + 3'd1;
                        if (blk == LAST_Y_BLK) begin
                            state <= CB;
                        end
                    end
                end
                CB: begin
                    if (blk_end) begin
                        blk   <= 3'(BLKS_PER_MCU - 1);
                        state <= CR;
                    end
                end
                CR: begin
                    if (blk_end) begin
                        blk <= '0;
                        if (mcu_idx == num_q - MCU_W'(1)) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            mcu_idx <= mcu_idx + MCU_W'(1);
                            state   <= Y;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// tb/tb_jpeg_mcu_scheduler.sv - scoreboard bench for jpeg_mcu_scheduler
module tb_jpeg_mcu_scheduler;

    localparam int DW = 8;
    localparam int MW = 16;
    localparam int SRC_N = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [MW-1:0] num_mcu = '0;
    logic          y_valid = 1'b0, cb_valid = 1'b0, cr_valid = 1'b0;
    logic [DW-1:0] y_data = '0, cb_data = '0, cr_data = '0;
    logic          y_ready, cb_ready, cr_ready;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_comp;
    logic [2:0]    out_blk;
    logic          out_last, busy, done;
    logic [MW-1:0] mcu_idx;

    jpeg_mcu_scheduler #(.DATA_W(DW), .MCU_W(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_mcu(num_mcu),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .cb_valid(cb_valid), .cb_data(cb_data), .cb_ready(cb_ready),
        .cr_valid(cr_valid), .cr_data(cr_data), .cr_ready(cr_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_comp(out_comp), .out_blk(out_blk), .out_last(out_last),
        .busy(busy), .done(done), .mcu_idx(mcu_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int comp;
        int blk;
        int mcu;
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   src[3][SRC_N];
    int   sidx[3], mptr[3], vmode[3];
    int   rmode = 1;
    bit   fire[3];
    int   xfers = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0, done_cyc = 0, dc0 = 0, st_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: a frame is n MCUs, each 4 Y blocks, 1 Cb, 1 Cr of 64 samples taken in stream order
    task automatic push_frame(input int n);
        exp_t e;
        for (int m = 0; m < n; m++)
            for (int b = 0; b < 6; b++)
                for (int s = 0; s < 64; s++) begin
                    e.comp = (b < 4) ? 0 : ((b == 4) ? 1 : 2);
                    e.blk  = b;
                    e.mcu  = m;
                    e.last = (s == 63);
                    e.data = src[e.comp][mptr[e.comp] % SRC_N];
                    mptr[e.comp]++;
                    exp_q.push_back(e);
                end
    endtask

    // Sources and sink: advance consumed streams, then redrive valids/data/ready
    initial forever begin
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (fire[c]) sidx[c]++;
            fire[c] = 1'b0;
        end
        y_valid  = (vmode[0] == 1) || (vmode[0] == 2 && $urandom_range(3) != 0);
        cb_valid = (vmode[1] == 1) || (vmode[1] == 2 && $urandom_range(3) != 0);
        cr_valid = (vmode[2] == 1) || (vmode[2] == 2 && $urandom_range(3) != 0);
        y_data   = DW'(src[0][sidx[0] % SRC_N]);
        cb_data  = DW'(src[1][sidx[1] % SRC_N]);
        cr_data  = DW'(src[2][sidx[2] % SRC_N]);
        if (rmode == 1)      out_ready = 1'b1;
        else if (rmode == 2) out_ready = ~out_ready;
        else                 out_ready = ($urandom_range(3) != 0);
    end

    // Monitor: routing/tag checks every busy cycle, pop and compare on each transfer
    initial forever begin
        exp_t e;
        bit   av;
        @(negedge clk);
        if (!rst) begin
            if (!busy) begin
                chk("idle_ready_valid", {y_ready, cb_ready, cr_ready, out_valid}, 0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_busy", 1, 0);
            end else begin
                e  = exp_q[0];
                av = (e.comp == 0) ? y_valid : ((e.comp == 1) ? cb_valid : cr_valid);
                chk("out_comp", out_comp, e.comp);
                chk("out_blk", out_blk, e.blk);
                chk("mcu_idx", mcu_idx, e.mcu);
                chk("out_valid", out_valid, av);
                chk("readies", {y_ready, cb_ready, cr_ready},
                    {e.comp == 0 && out_ready, e.comp == 1 && out_ready, e.comp == 2 && out_ready});
                chk("out_last", out_last, av && e.last);
                if (out_valid && out_ready) begin
                    chk("out_data", out_data, e.data);
                    void'(exp_q.pop_front());
                    fire[e.comp] = 1'b1;
                    if (xfers == 0) first_cyc = cyc;
                    xfers++;
                    last_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_frame(input int n);
        @(negedge clk);
        #2;
        start   = 1'b1;
        num_mcu = MW'(n);
        push_frame(n);
        xfers  = 0;
        dc0    = done_cnt;
        st_cyc = cyc;
        @(negedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int budget, input bit has_xfer);
        int n = 0;
        while (done_cnt == dc0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({name, "_done_seen"}, done_cnt, dc0 + 1);
        if (has_xfer) chk({name, "_done_latency"}, done_cyc, last_cyc + 1);
        else          chk({name, "_done_latency"}, done_cyc, st_cyc + 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        @(negedge clk);
        #2;
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_single_done"}, done_cnt, dc0 + 1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xfers < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("wait_xfers_reached", xfers >= target, 1);
    endtask

    initial begin
        int n0;
        for (int c = 0; c < 3; c++) begin
            sidx[c] = 0; mptr[c] = 0; vmode[c] = 1; fire[c] = 1'b0;
            for (int i = 0; i < SRC_N; i++) src[c][i] = $urandom_range(255);
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mcu_idx", mcu_idx, 0);
        chk("rst_tags", {out_comp, out_blk, out_last}, 0);
        chk("rst_ready_valid", {y_ready, cb_ready, cr_ready, out_valid}, 0);
        rst = 1'b0;

        // One MCU at full rate: 384 back-to-back transfers
        start_frame(1);
        wait_frame("full_rate", 2000, 1);
        chk("full_rate_xfers", xfers, 384);
        chk("full_rate_first", first_cyc, st_cyc + 1);
        chk("full_rate_span", last_cyc - first_cyc + 1, 384);

        // Two MCUs with out_ready toggling
        rmode = 2;
        start_frame(2);
        wait_frame("toggle", 4000, 1);
        chk("toggle_xfers", xfers, 768);

        // Empty frame
        rmode = 1;
        start_frame(0);
        wait_frame("empty", 20, 0);
        chk("empty_xfers", xfers, 0);

        // start pulsed during Y is ignored
        for (int c = 0; c < 3; c++) vmode[c] = 2;
        rmode = 3;
        start_frame(1);
        wait_xfers(100, 2000);
        start   = 1'b1;
        num_mcu = MW'(5);
        @(negedge clk);
        #2;
        start = 1'b0;
        wait_frame("restart_ignored", 3000, 1);
        chk("restart_ignored_xfers", xfers, 384);

        // Reset 30 samples into the Cb block
        for (int c = 0; c < 3; c++) vmode[c] = 1;
        rmode = 1;
        start_frame(1);
        wait_xfers(286, 1000);
        rst = 1'b1;
        @(posedge clk);
        #2;
        exp_q.delete();
        for (int c = 0; c < 3; c++) mptr[c] = sidx[c];
        dc0 = done_cnt;
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("midrst_busy", busy, 0);
            chk("midrst_mcu_idx", mcu_idx, 0);
            chk("midrst_done", done, 0);
        end
        chk("midrst_no_done", done_cnt, dc0);
        start_frame(1);
        wait_frame("replay", 2000, 1);
        chk("replay_xfers", xfers, 384);

        // Cb source stalled for 50 cycles
        vmode[1] = 0;
        start_frame(1);
        begin
            int n = 0;
            while (!(exp_q.size() > 0 && exp_q[0].comp == 1) && n < 1000) begin
                @(negedge clk);
                #2;
                n++;
            end
        end
        n0 = xfers;
        repeat (50) begin
            @(negedge clk);
            #2;
            chk("stall_y_ready", y_ready, 0);
            chk("stall_cr_ready", cr_ready, 0);
            chk("stall_comp", out_comp, 1);
            chk("stall_busy", busy, 1);
        end
        chk("stall_frozen", xfers, n0);
        vmode[1] = 1;
        wait_frame("stall", 2000, 1);
        chk("stall_xfers", xfers, 384);

        // Random frames with random valids and backpressure
        for (int c = 0; c < 3; c++) vmode[c] = 2;
        rmode = 3;
        repeat (3) begin
            int n = $urandom_range(1, 3);
            start_frame(n);
            wait_frame("random", 10000, 1);
            chk("random_xfers", xfers, 384 * n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        n_bad++;
        $display("FAIL global_timeout: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
